// File: rtl/pio_input_edge_capture.sv
// Avalon-MM input PIO: synchronises and debounces pins, captures selected edges into
// sticky bits and raises a maskable level interrupt.
module pio_input_edge_capture #(
  parameter int unsigned     WIDTH           = 8,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     CNT_W           = 16,
  parameter int unsigned     EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrEdgeCap = 2'd3;

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            stable_dly_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [WIDTH-1:0]            edge_event;
  logic [WIDTH-1:0]            clear_mask;
  logic [31:0]                 readdata_d;
  logic                        wr_en;

  // Bits of writedata above WIDTH carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^{1'b0, writedata};

  assign wr_en = chipselect & ~write_n;

  // Per-bit debounce: a differing level must persist DEBOUNCE_CYCLES edges at sync2.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    edge_event = '0;
    case (EDGE_TYPE)
      0:       edge_event = stable_q & ~stable_dly_q;
      1:       edge_event = ~stable_q & stable_dly_q;
      default: edge_event = stable_q ^ stable_dly_q;
    endcase
  end

  always_comb begin
    clear_mask = '0;
    irqmask_d  = irqmask_q;
    if (wr_en && (address == AddrEdgeCap)) begin
      clear_mask = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == AddrIrqMask)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  // A new event overrides a simultaneous write-1-to-clear.
  assign edgecap_d = (edgecap_q & ~clear_mask) | edge_event;

  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[WIDTH-1:0] = stable_q;
      AddrIrqMask: readdata_d[WIDTH-1:0] = irqmask_q;
      AddrEdgeCap: readdata_d[WIDTH-1:0] = edgecap_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= RESET_VAL;
      sync2_q      <= RESET_VAL;
      stable_q     <= RESET_VAL;
      stable_dly_q <= RESET_VAL;
      cnt_q        <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      readdata     <= '0;
    end else begin
      sync1_q      <= in_port;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata     <= readdata_d;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_input_edge_capture.sv
// Self-checking bench: register-access vector table, directed debounce/capture sequences and
// randomized traffic compared against a sliding-window reference model.
module tb_pio_input_edge_capture;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  pins;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int failures = 0;

  pio_input_edge_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16),
    .EDGE_TYPE      (1),
    .RESET_VAL      (8'hFF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (pins),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronised samples all differ from it.
  logic [W-1:0] m_s1, m_s2, m_stable, m_stable_dly, m_ecap, m_mask;
  logic [31:0]  m_rd;
  logic [W-1:0] m_win[$];

  function automatic logic m_irq();
    return |(m_ecap & m_mask);
  endfunction

  task automatic model_reset();
    m_s1 = 8'hFF; m_s2 = 8'hFF; m_stable = 8'hFF; m_stable_dly = 8'hFF;
    m_ecap = '0; m_mask = '0; m_rd = '0;
    m_win.delete();
  endtask

  task automatic model_edge(input logic c, input logic w, input logic [1:0] a,
                            input logic [31:0] d, input logic [W-1:0] p);
    logic [W-1:0] nstable, ev, nec;
    logic [31:0]  rd;
    logic         all_diff;
    nstable = m_stable;
    m_win.push_back(m_s2);
    if (m_win.size() > D) void'(m_win.pop_front());
    if (m_win.size() == D) begin
      for (int b = 0; b < int'(W); b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nstable[b] = ~m_stable[b];
      end
    end
    ev = ~m_stable & m_stable_dly;
    case (a)
      2'd0:    rd = {24'd0, m_stable};
      2'd2:    rd = {24'd0, m_mask};
      2'd3:    rd = {24'd0, m_ecap};
      default: rd = 32'd0;
    endcase
    nec = m_ecap;
    if (c && !w && a == 2'd3) nec = nec & ~d[W-1:0];
    nec = nec | ev;
    if (c && !w && a == 2'd2) m_mask = d[W-1:0];
    m_s2 = m_s1;
    m_s1 = p;
    m_stable_dly = m_stable;
    m_stable = nstable;
    m_ecap = nec;
    m_rd = rd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive bus, take the edge, then compare against the model 1 ns later.
  task automatic step(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
    chipselect = c; write_n = w; address = a; writedata = d;
    @(posedge clk);
    model_edge(c, w, a, d, pins);
    #1;
    check("model_readdata", readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic idle_read(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, a, 32'd0);
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0000_005A, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0000_005A, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0000_005A, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0000_005A, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'd3, 32'h0,         32'h0000_0000, 1'b0};

    reset_n = 1'b0; pins = 8'hFF;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;

    // Register map access vectors with idle pins.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // Bit0 falls: stable at edge 6, captured at edge 7, no irq with mask 0.
    pins = 8'hFE;
    idle_read(6, 2'd0);
    check("stable_before_edge6", readdata, 32'h0000_00FF);
    idle_read(1, 2'd0);
    check("stable_after_edge6", readdata, 32'h0000_00FE);
    idle_read(1, 2'd3);
    check("capture_bit0", readdata, 32'h0000_0001);
    check("irq_masked", {31'd0, irq}, 32'h0);

    // Masked-in capture raises irq; write-1 clears it.
    step(1'b1, 1'b0, 2'd2, 32'h1);
    pins = 8'hFF;
    idle_read(8, 2'd0);
    step(1'b1, 1'b0, 2'd3, 32'h1);
    pins = 8'hFE;
    idle_read(6, 2'd0);
    check("irq_before_capture", {31'd0, irq}, 32'h0);
    idle_read(1, 2'd0);
    check("irq_on_capture", {31'd0, irq}, 32'h1);
    step(1'b1, 1'b0, 2'd3, 32'h1);
    check("irq_after_clear", {31'd0, irq}, 32'h0);
    idle_read(1, 2'd3);
    check("ecap_after_clear", readdata, 32'h0);
    pins = 8'hFF;
    idle_read(8, 2'd0);

    // Glitch of D-1 cycles is rejected; a 6-cycle pulse is accepted.
    pins = 8'hF7;
    idle_read(3, 2'd0);
    pins = 8'hFF;
    idle_read(8, 2'd3);
    check("glitch_no_capture", readdata, 32'h0);
    idle_read(1, 2'd0);
    check("glitch_stable", readdata, 32'h0000_00FF);
    pins = 8'hF7;
    idle_read(6, 2'd0);
    pins = 8'hFF;
    idle_read(8, 2'd3);
    check("pulse_capture", readdata, 32'h0000_0008);

    // Set beats a same-cycle clear.
    step(1'b1, 1'b0, 2'd3, 32'hFF);
    pins = 8'hFB;
    idle_read(6, 2'd0);
    step(1'b1, 1'b0, 2'd3, 32'h4);
    idle_read(1, 2'd3);
    check("set_wins_over_clear", readdata, 32'h0000_0004);
    pins = 8'hFF;
    idle_read(8, 2'd0);

    // Async reset mid-debounce with pending captures and irq asserted.
    step(1'b1, 1'b0, 2'd3, 32'hFF);
    step(1'b1, 1'b0, 2'd2, 32'h9);
    pins = 8'hF6;
    idle_read(7, 2'd0);
    pins = 8'hFF;
    idle_read(4, 2'd3);
    check("ecap_before_reset", readdata, 32'h0000_0009);
    check("irq_before_reset", {31'd0, irq}, 32'h1);
    reset_n = 1'b0;
    chipselect = 1'b0;
    #1;
    check("irq_async_reset", {31'd0, irq}, 32'h0);
    check("readdata_async_reset", readdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_read(10, 2'd3);
    check("no_capture_after_reset", readdata, 32'h0);
    idle_read(1, 2'd0);
    check("stable_after_reset", readdata, 32'h0000_00FF);
    idle_read(1, 2'd2);
    check("mask_after_reset", readdata, 32'h0);

    // Randomized pins and bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) pins[$urandom_range(0, W - 1)] ^= 1'b1;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
